// File: rtl/bus_arbiter_mem_pkg.sv
// Shared definitions for the dual-core bus arbiter: FSM encoding, grant
// levels, core indices and a one-hot grant helper.
package bus_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic BUS_GRANTED     = 1'b1;
  localparam logic BUS_NOT_GRANTED = 1'b0;

  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;

  // One-hot grant vector for the given core index
  function automatic logic [1:0] onehot2(input logic idx);
    logic [1:0] g;
    g      = {2{BUS_NOT_GRANTED}};
    g[idx] = BUS_GRANTED;
    return g;
  endfunction

endpackage

// File: rtl/bus_arbiter_mem_if.sv
// Processor bus handshake between the two cores (master) and the
// arbiter/memory responder (slave).
interface bus_arbiter_mem_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);

  logic [1:0]            bus_request_in;
  logic [ADDR_WIDTH-1:0] addr0_in;
  logic [ADDR_WIDTH-1:0] addr1_in;
  logic [1:0]            bus_grant_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic [3:0]            beat_out;

  modport master (
    output bus_request_in, addr0_in, addr1_in,
    input  bus_grant_out, data_out, beat_out
  );

  modport slave (
    input  bus_request_in, addr0_in, addr1_in,
    output bus_grant_out, data_out, beat_out
  );

endinterface

// File: rtl/bus_arbiter_mem_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins outright; on a tie the
// core that did not win last time gets the bus.
module rr_arbiter2
  import bus_defs::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       grant_vld,
  output logic       winner
);

  // Combinational winner selection
  always_comb begin
    grant_vld = |req;
    winner    = CORE0;
    if (req == 2'b11) begin
      winner = (rr_last == CORE0) ? CORE1 : CORE0;
    end else if (req[1]) begin
      winner = CORE1;
    end
  end

endmodule

// File: rtl/bus_arbiter_mem.sv
// Shared-bus responder: arbitrates two cores and returns a BURST_LEN-word
// burst from local memory starting at the winner's address.
// Optional feature macro: GRANT_EARLY_RELEASE_EN (burst ends early when the
// granted core drops its request).
module bus_arbiter_mem
  import bus_defs::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 2
) (
  input  logic                  clk,
  input  logic                  reset_in,
  bus_arbiter_mem_if.slave      bus,
  input  logic                  mem_we_in,
  input  logic [ADDR_WIDTH-1:0] mem_waddr_in,
  input  logic [DATA_WIDTH-1:0] mem_wdata_in
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  state_t                state_q, state_nxt;
  logic [1:0]            grant_q, grant_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic [3:0]            beat_q, beat_nxt;
  logic                  rr_last_q, rr_last_nxt;
  logic [ADDR_WIDTH-1:0] base_q, base_nxt;

  logic                  arb_vld;
  logic                  winner;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  last_beat;
  logic                  burst_end;

  rr_arbiter2 u_arb (
    .req       (bus.bus_request_in),
    .rr_last   (rr_last_q),
    .grant_vld (arb_vld),
    .winner    (winner)
  );

  assign win_addr  = (winner == CORE1) ? bus.addr1_in : bus.addr0_in;
  // Burst addresses wrap modulo the memory depth
  assign rd_addr   = base_q + ADDR_WIDTH'(beat_q) + ADDR_WIDTH'(1);
  assign last_beat = (beat_q >= 4'(BURST_LEN - 1));

`ifdef GRANT_EARLY_RELEASE_EN
  assign burst_end = last_beat || ((bus.bus_request_in & grant_q) == 2'b00);
`else
  assign burst_end = last_beat;
`endif

  // Memory load port; reads in the same cycle see the previous contents
  always_ff @(posedge clk) begin
    if (mem_we_in) begin
      mem[mem_waddr_in] <= mem_wdata_in;
    end
  end

  // State and control registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      data_q    <= '0;
      beat_q    <= 4'd0;
      rr_last_q <= CORE1;
    end else begin
      state_q   <= state_nxt;
      grant_q   <= grant_nxt;
      data_q    <= data_nxt;
      beat_q    <= beat_nxt;
      rr_last_q <= rr_last_nxt;
    end
  end

  // Burst base address only matters while granted, so it carries no reset
  always_ff @(posedge clk) begin
    base_q <= base_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (arb_vld) state_nxt = GRANT;
      GRANT:   if (burst_end) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of grant, data, beat, base and round-robin pointer
  always_comb begin
    grant_nxt   = {2{BUS_NOT_GRANTED}};
    data_nxt    = '0;
    beat_nxt    = 4'd0;
    base_nxt    = base_q;
    rr_last_nxt = rr_last_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_nxt   = onehot2(winner);
          base_nxt    = win_addr;
          data_nxt    = mem[win_addr];
          rr_last_nxt = winner;
        end
      end
      GRANT: begin
        if (!burst_end) begin
          grant_nxt = grant_q;
          beat_nxt  = beat_q + 4'd1;
          data_nxt  = mem[rd_addr];
        end
      end
      default: begin
        grant_nxt = {2{BUS_NOT_GRANTED}};
      end
    endcase
  end

  assign bus.bus_grant_out = grant_q;
  assign bus.data_out      = data_q;
  assign bus.beat_out      = beat_q;

endmodule

// File: tb/tb_bus_arbiter_mem.sv
// Self-checking bench for bus_arbiter_mem: a BURST_LEN=2 instance checked
// through an expected-beat queue, plus a BURST_LEN=4 instance for the
// early-release behaviour (GRANT_EARLY_RELEASE_EN).
module tb_bus_arbiter_mem;

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic       mem_we_in = 1'b0;
  logic [3:0] mem_waddr_in = 4'h0;
  logic [7:0] mem_wdata_in = 8'h00;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] g;
    logic [7:0] d;
    logic [3:0] b;
  } beat_t;

  beat_t      sb[$];
  beat_t      mon_e;
  logic [7:0] mdl [16];

`ifdef GRANT_EARLY_RELEASE_EN
  localparam int EXP_EARLY_BEATS = 2;
`else
  localparam int EXP_EARLY_BEATS = 4;
`endif

  bus_arbiter_mem_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) busa ();
  bus_arbiter_mem_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) busb ();

  bus_arbiter_mem #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .BURST_LEN(2)) u_dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .bus          (busa),
    .mem_we_in    (mem_we_in),
    .mem_waddr_in (mem_waddr_in),
    .mem_wdata_in (mem_wdata_in)
  );

  bus_arbiter_mem #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .BURST_LEN(4)) u_dut4 (
    .clk          (clk),
    .reset_in     (reset_in),
    .bus          (busb),
    .mem_we_in    (mem_we_in),
    .mem_waddr_in (mem_waddr_in),
    .mem_wdata_in (mem_wdata_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Every granted cycle of the main instance is matched against the queue
  always @(negedge clk) begin
    if (busa.bus_grant_out != 2'b00) begin
      check("grant_onehot", 32'($onehot(busa.bus_grant_out)), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'(busa.bus_grant_out), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_grant", 32'(busa.bus_grant_out), 32'(mon_e.g));
        check("sb_data",  32'(busa.data_out),      32'(mon_e.d));
        check("sb_beat",  32'(busa.beat_out),      32'(mon_e.b));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_in = 1'b1;
    @(posedge clk); #1;
    check("rst_grant", 32'(busa.bus_grant_out), 32'd0);
    check("rst_data",  32'(busa.data_out),      32'd0);
    check("rst_beat",  32'(busa.beat_out),      32'd0);
    @(posedge clk); #1;
    reset_in = 1'b0;
  endtask

  task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
    mem_we_in = 1'b1; mem_waddr_in = a; mem_wdata_in = d;
    @(posedge clk); #1;
    mem_we_in = 1'b0;
    mdl[a] = d;
  endtask

  task automatic push_burst(input int core, input logic [3:0] addr);
    beat_t      e;
    logic [3:0] a;
    for (int i = 0; i < 2; i++) begin
      a   = addr + 4'(i);
      e.g = (core == 1) ? 2'b10 : 2'b01;
      e.d = mdl[a];
      e.b = 4'(i);
      sb.push_back(e);
    end
  endtask

  task automatic wait_grant(input string tag, output int n);
    n = 0;
    while (busa.bus_grant_out == 2'b00 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_fall(input string tag);
    int n = 0;
    while (busa.bus_grant_out != 2'b00 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check(tag, 32'd0, 32'd1);
  endtask

  task automatic run_burst(input int core, input logic [3:0] addr);
    int n;
    push_burst(core, addr);
    if (core == 1) busa.addr1_in = addr; else busa.addr0_in = addr;
    busa.bus_request_in[core] = 1'b1;
    wait_grant("grant_timeout", n);
    check("latency", 32'(n), 32'd1);
    wait_fall("fall_timeout");
    busa.bus_request_in[core] = 1'b0;
    check("post_data", 32'(busa.data_out), 32'd0);
    check("post_beat", 32'(busa.beat_out), 32'd0);
    check("sb_drain",  32'(sb.size()),     32'd0);
  endtask

  initial begin
    int         n;
    int         nb;
    logic [1:0] exp_g;
    logic [3:0] a;
    busa.bus_request_in = 2'b00; busa.addr0_in = 4'h0; busa.addr1_in = 4'h0;
    busb.bus_request_in = 2'b00; busb.addr0_in = 4'h0; busb.addr1_in = 4'h0;
    do_reset();

    // Single core0 burst
    write_mem(4'h5, 8'h55);
    write_mem(4'h6, 8'hAA);
    run_burst(0, 4'h5);

    // core1 burst wrapping from 4'hF to 0
    write_mem(4'hF, 8'h11);
    write_mem(4'h0, 8'h22);
    run_burst(1, 4'hF);

    // Both cores requesting continuously from reset
    do_reset();
    push_burst(0, 4'h5); push_burst(1, 4'hF);
    push_burst(0, 4'h5); push_burst(1, 4'hF);
    busa.addr0_in = 4'h5; busa.addr1_in = 4'hF;
    busa.bus_request_in = 2'b11;
    wait_grant("cont_timeout", n);
    for (int k = 0; k < 16; k++) begin
      exp_g = ((k % 8) < 2) ? 2'b01 : (((k % 8) == 4 || (k % 8) == 5) ? 2'b10 : 2'b00);
      check("cont_grant", 32'(busa.bus_grant_out), 32'(exp_g));
      if (k == 15) busa.bus_request_in = 2'b00;
      else begin @(posedge clk); #1; end
    end
    repeat (3) begin @(posedge clk); #1; end
    check("cont_idle", 32'(busa.bus_grant_out), 32'd0);
    check("cont_drain", 32'(sb.size()), 32'd0);

    // Reset on the second beat of a core0 burst
    push_burst(0, 4'h5);
    busa.addr0_in = 4'h5;
    busa.bus_request_in = 2'b01;
    wait_grant("rst_burst_timeout", n);
    @(posedge clk); #5;
    reset_in = 1'b1;
    #1;
    check("midrst_grant", 32'(busa.bus_grant_out), 32'd0);
    check("midrst_data",  32'(busa.data_out),      32'd0);
    check("midrst_beat",  32'(busa.beat_out),      32'd0);
    busa.bus_request_in = 2'b00;
    @(posedge clk); #1;
    reset_in = 1'b0;
    check("midrst_drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    check("no_resume", 32'(busa.bus_grant_out), 32'd0);

    // First tie after reset goes to core0
    push_burst(0, 4'h5);
    busa.addr1_in = 4'hF;
    busa.bus_request_in = 2'b11;
    wait_grant("tie_timeout", n);
    check("tie_after_reset", 32'(busa.bus_grant_out), 32'h1);
    busa.bus_request_in = 2'b01;
    wait_fall("tie_fall_timeout");
    busa.bus_request_in = 2'b00;
    check("tie_drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Write to mem[6] on the same edge that reads it
    sb.push_back('{g: 2'b01, d: 8'h55, b: 4'd0});
    sb.push_back('{g: 2'b01, d: 8'hAA, b: 4'd1});
    busa.addr0_in = 4'h5;
    busa.bus_request_in = 2'b01;
    wait_grant("wr_timeout", n);
    mem_we_in = 1'b1; mem_waddr_in = 4'h6; mem_wdata_in = 8'h77;
    @(posedge clk); #1;
    mem_we_in = 1'b0;
    mdl[6] = 8'h77;
    wait_fall("wr_fall_timeout");
    busa.bus_request_in = 2'b00;
    check("wr_drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    run_burst(0, 4'h5);

    // Request drop after beat 1 on the four-beat instance
    write_mem(4'h8, 8'h81);
    write_mem(4'h9, 8'h92);
    write_mem(4'hA, 8'hA3);
    write_mem(4'hB, 8'hB4);
    busb.addr0_in = 4'h8;
    busb.bus_request_in = 2'b01;
    n = 0;
    while (busb.bus_grant_out == 2'b00 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check("b4_timeout", 32'd0, 32'd1);
    nb = 0;
    while (busb.bus_grant_out != 2'b00 && nb < 10) begin
      a = 4'h8 + 4'(nb);
      check("b4_grant", 32'(busb.bus_grant_out), 32'h1);
      check("b4_data",  32'(busb.data_out),      32'(mdl[a]));
      check("b4_beat",  32'(busb.beat_out),      32'(nb));
      nb++;
      if (nb == 2) busb.bus_request_in = 2'b00;
      @(posedge clk); #1;
    end
    check("b4_beats", 32'(nb), 32'(EXP_EARLY_BEATS));
    check("b4_post_data", 32'(busb.data_out), 32'd0);
    busb.bus_request_in = 2'b00;

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
